// File: rtl/run_sequencer.sv
// run_sequencer
// -------------
// Upstream launcher for the 9-bit core. A Go request runs NPROG programs
// back to back. For each program the block holds Start high for
// START_CYCLES cycles, then counts RUN cycles until the core raises Ack.
// A watchdog aborts the sequence when a program reaches TIMEOUT RUN cycles
// without an Ack.
//
// Handshake: Start is a registered strobe held for START_CYCLES cycles.
// Ack is only looked at while in RUN, where it acts as a one-cycle
// "program done" flag. No Ack is expected or consumed in any other state.
//
// Ports
//   Clk       in        single clock, posedge
//   Reset     in        synchronous, active-high
//   Go        in        start a sequence (sampled in IDLE only)
//   Ack       in        core done flag (sampled in RUN only)
//   Start     out       core start strobe (registered)
//   ProgIdx   out [1:0] 0-based program index being launched/run
//   Busy      out       high whenever not IDLE
//   CycleCnt  out [CW]  RUN-cycle count of the last finished program
//   CntValid  out       one-cycle pulse when CycleCnt updates
//   Done      out       one-cycle pulse at end of sequence (normal or abort)
//   Timeout   out       sticky watchdog flag, cleared by the next Go
//   DbgState  out [1:0] current FSM state (0 IDLE, 1 LAUNCH, 2 RUN, 3 FINISH)
module run_sequencer #(
    parameter int             NPROG        = 3,
    parameter int             START_CYCLES = 2,
    parameter int             CW           = 16,
    parameter logic [CW-1:0]  TIMEOUT      = CW'(16'hFFFF)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Ack,
    output logic          Start,
    output logic [1:0]    ProgIdx,
    output logic          Busy,
    output logic [CW-1:0] CycleCnt,
    output logic          CntValid,
    output logic          Done,
    output logic          Timeout,
    output logic [1:0]    DbgState
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam int             LW          = $clog2(START_CYCLES + 1);
    localparam logic [LW-1:0]  LAUNCH_LAST = LW'(START_CYCLES);
    localparam logic [1:0]     LAST_PROG   = 2'(NPROG - 1);

    state_t          state_q, state_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;       // Start-high cycles issued so far
    logic [CW-1:0]   run_cnt_q, run_cnt_d; // RUN cycles completed before this one
    logic [1:0]      prog_q, prog_d;
    logic            start_q, start_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic            cv_q, cv_d;
    logic            done_q, done_d;
    logic            to_q, to_d;

    // Count including the current RUN cycle. run_cnt_q never exceeds
    // TIMEOUT-1, so this cannot wrap.
    logic [CW-1:0]   run_next;
    assign run_next = run_cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        lcnt_d    = lcnt_q;
        run_cnt_d = run_cnt_q;
        prog_d    = prog_q;
        start_d   = start_q;
        cyc_d     = cyc_q;
        cv_d      = 1'b0;
        done_d    = 1'b0;
        to_d      = to_q;

        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    to_d    = 1'b0;
                    prog_d  = 2'd0;
                    // Entry from IDLE spends one cycle with Start still low,
                    // so the strobe begins one edge after Go is taken.
                    lcnt_d  = '0;
                    start_d = 1'b0;
                    state_d = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                if (lcnt_q == LAUNCH_LAST) begin
                    start_d   = 1'b0;
                    run_cnt_d = '0;
                    state_d   = S_RUN;
                end else begin
                    start_d = 1'b1;
                    lcnt_d  = lcnt_q + LW'(1);
                end
            end

            S_RUN: begin
                start_d = 1'b0;
                if (Ack) begin
                    // Ack wins over the watchdog in the same cycle.
                    cyc_d = run_next;
                    cv_d  = 1'b1;
                    if (prog_q == LAST_PROG) begin
                        state_d = S_FINISH;
                    end else begin
                        // Relaunch raises Start on this edge, so the first
                        // strobe cycle is already counted.
                        prog_d  = prog_q + 2'd1;
                        start_d = 1'b1;
                        lcnt_d  = LW'(1);
                        state_d = S_LAUNCH;
                    end
                end else if (run_next == TIMEOUT) begin
                    to_d    = 1'b1;
                    cyc_d   = TIMEOUT;
                    cv_d    = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    run_cnt_d = run_next;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            lcnt_q    <= '0;
            run_cnt_q <= '0;
            prog_q    <= 2'd0;
            start_q   <= 1'b0;
            cyc_q     <= '0;
            cv_q      <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            lcnt_q    <= lcnt_d;
            run_cnt_q <= run_cnt_d;
            prog_q    <= prog_d;
            start_q   <= start_d;
            cyc_q     <= cyc_d;
            cv_q      <= cv_d;
            done_q    <= done_d;
            to_q      <= to_d;
        end
    end

    assign Start    = start_q;
    assign ProgIdx  = prog_q;
    assign Busy     = (state_q != S_IDLE);
    assign CycleCnt = cyc_q;
    assign CntValid = cv_q;
    assign Done     = done_q;
    assign Timeout  = to_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Testbench for run_sequencer (NPROG=3, START_CYCLES=2, TIMEOUT=50).
// Drivers and checks act on the falling clock edge; the DUT acts on the
// rising edge. Expected CycleCnt values and expected Timeout-at-Done values
// are queued by the stimulus and consumed by a monitor.
module tb_run_sequencer;

    localparam int             CW      = 16;
    localparam int             SC      = 2;
    localparam logic [CW-1:0]  TO_LIM  = 16'd50;

    logic          Clk;
    logic          Reset;
    logic          Go;
    logic          Ack;
    logic          Start;
    logic [1:0]    ProgIdx;
    logic          Busy;
    logic [CW-1:0] CycleCnt;
    logic          CntValid;
    logic          Done;
    logic          Timeout;
    logic [1:0]    DbgState;

    int errors = 0;
    int checks = 0;

    logic [CW-1:0] exp_q[$];
    logic [0:0]    done_exp_q[$];
    logic [CW-1:0] exp_cnt;
    logic [0:0]    exp_to;
    int            start_len = 0;
    int            start_rises = 0;
    int            rises_snap;

    run_sequencer #(
        .NPROG(3),
        .START_CYCLES(SC),
        .CW(CW),
        .TIMEOUT(TO_LIM)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Go(Go),
        .Ack(Ack),
        .Start(Start),
        .ProgIdx(ProgIdx),
        .Busy(Busy),
        .CycleCnt(CycleCnt),
        .CntValid(CntValid),
        .Done(Done),
        .Timeout(Timeout),
        .DbgState(DbgState)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "global timeout");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge Clk) begin
        if (CntValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cnt_valid_unexpected: CycleCnt=%0d, required no pulse", CycleCnt);
            end else begin
                exp_cnt = exp_q.pop_front();
                check("cycle_cnt", CycleCnt, exp_cnt);
            end
        end
        if (Done === 1'b1) begin
            if (done_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: Done=1, required no pulse");
            end else begin
                exp_to = done_exp_q.pop_front();
                check("done_timeout", Timeout, exp_to);
                check("done_busy", Busy, 0);
            end
        end
        // Start strobe width
        if (Start === 1'b1) begin
            if (start_len == 0) start_rises++;
            start_len++;
        end else if (start_len != 0) begin
            check("start_width", start_len, SC);
            start_len = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_go();
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
    endtask

    // Core model: wait for a launch, then ack on RUN cycle k (k=0: no ack,
    // return at RUN cycle 1). Optionally hold Ack during the Start strobe
    // and pulse Go on RUN cycle 3.
    task automatic run_prog(input int k, input logic [1:0] idx,
                            input bit ack_launch, input bit go_in_run);
        int n;
        n = 0;
        while (Start !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check("launch_seen", Start, 1);
        n = 0;
        while (Start === 1'b1 && n < 40) begin
            Ack = ack_launch;
            @(negedge Clk);
            n++;
        end
        Ack = 1'b0;
        check("run_entered", Start, 0);
        check("run_prog_idx", ProgIdx, idx);
        check("run_busy", Busy, 1);
        if (k > 0) begin
            for (int j = 1; j <= k; j++) begin
                Go  = (go_in_run && j == 3);
                Ack = (j == k);
                @(negedge Clk);
            end
            Ack = 1'b0;
            Go  = 1'b0;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (Busy !== 1'b0 && n < limit) begin
            @(negedge Clk);
            n++;
        end
        check("idle_reached", Busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1;
        Go    = 1'b0;
        Ack   = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_outputs", {Start, Busy, CntValid, Done, Timeout, ProgIdx, CycleCnt}, 0);
        Reset = 1'b0;

        // Idle with Ack toggling: nothing may happen.
        for (int i = 0; i < 5; i++) begin
            Ack = (i % 2 == 0);
            @(negedge Clk);
            check("idle_outputs", {Start, Busy, CntValid, Done, Timeout, ProgIdx, CycleCnt}, 0);
        end
        Ack = 1'b0;

        // Normal sequence: acks after 10, 20, 30 RUN cycles.
        exp_q.push_back(16'd10);
        exp_q.push_back(16'd20);
        exp_q.push_back(16'd30);
        done_exp_q.push_back(1'b0);
        pulse_go();
        check("go_busy", Busy, 1);
        run_prog(10, 2'd0, 1'b0, 1'b0);
        run_prog(20, 2'd1, 1'b0, 1'b0);
        run_prog(30, 2'd2, 1'b0, 1'b0);
        wait_idle(20);
        check("normal_timeout", Timeout, 0);
        check("normal_prog_hold", ProgIdx, 2);
        repeat (2) @(negedge Clk);

        // Watchdog: program 0 never acks.
        exp_q.push_back(TO_LIM);
        done_exp_q.push_back(1'b1);
        pulse_go();
        run_prog(0, 2'd0, 1'b0, 1'b0);
        rises_snap = start_rises;
        wait_idle(80);
        check("wd_timeout", Timeout, 1);
        check("wd_cycle_cnt", CycleCnt, TO_LIM);
        check("wd_no_relaunch", start_rises, rises_snap);
        check("wd_prog_idx", ProgIdx, 0);
        repeat (2) @(negedge Clk);

        // Ignored inputs and edge values: Ack held during launch, Go in RUN,
        // ack exactly on TIMEOUT, ack on the first RUN cycle.
        exp_q.push_back(16'd5);
        exp_q.push_back(TO_LIM);
        exp_q.push_back(16'd1);
        done_exp_q.push_back(1'b0);
        pulse_go();
        check("go_clears_timeout", Timeout, 0);
        run_prog(5, 2'd0, 1'b1, 1'b0);
        run_prog(50, 2'd1, 1'b1, 1'b1);
        run_prog(1, 2'd2, 1'b0, 1'b0);
        wait_idle(20);
        check("edge_timeout", Timeout, 0);
        repeat (2) @(negedge Clk);

        // Mid-run reset on RUN cycle 7 of program index 1.
        exp_q.push_back(16'd3);
        pulse_go();
        run_prog(3, 2'd0, 1'b0, 1'b0);
        run_prog(0, 2'd1, 1'b0, 1'b0);
        repeat (6) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_outputs", {Start, Busy, CntValid, Done, Timeout, ProgIdx, CycleCnt}, 0);
        repeat (3) @(negedge Clk);
        exp_q.push_back(16'd4);
        exp_q.push_back(16'd6);
        exp_q.push_back(16'd2);
        done_exp_q.push_back(1'b0);
        pulse_go();
        run_prog(4, 2'd0, 1'b0, 1'b0);
        run_prog(6, 2'd1, 1'b0, 1'b0);
        run_prog(2, 2'd2, 1'b0, 1'b0);
        wait_idle(20);
        repeat (2) @(negedge Clk);

        // Back-to-back: Go held high restarts right after Done.
        exp_q.push_back(16'd2);
        exp_q.push_back(16'd2);
        exp_q.push_back(16'd2);
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd3);
        done_exp_q.push_back(1'b0);
        done_exp_q.push_back(1'b0);
        Go = 1'b1;
        run_prog(2, 2'd0, 1'b0, 1'b0);
        Go = 1'b1;
        run_prog(2, 2'd1, 1'b0, 1'b0);
        Go = 1'b1;
        run_prog(2, 2'd2, 1'b0, 1'b0);
        Go = 1'b1;
        run_prog(3, 2'd0, 1'b0, 1'b0);
        Go = 1'b0;
        run_prog(3, 2'd1, 1'b0, 1'b0);
        run_prog(3, 2'd2, 1'b0, 1'b0);
        wait_idle(20);
        repeat (4) @(negedge Clk);
        check("b2b_stays_idle", Busy, 0);

        check("cnt_queue_empty", exp_q.size(), 0);
        check("done_queue_empty", done_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
